multicycle_control_unit: RTL and testbench

Parametrised FSM control unit for the multicycle RV32I core variant. It sequences fetch, decode, execute, memory and writeback over several cycles from the held instruction fields. It waits on a ready/valid memory handshake, resolves branches from datapath flags and optionally sequences a fixed-latency M-extension unit. It sits beside the shared datapath and drives every enable and mux select; it is the successor to the single-cycle/pipelined decoder pair.

---
 rtl/multicycle_control_unit.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//
// Control FSM for the multicycle RV32I core. It steps each instruction through
// fetch, decode, execute, memory and writeback using the instruction fields held
// in the IR. It waits on the memory ready handshake, resolves branches from the
// datapath compare flags, and can sequence a fixed-latency multiply/divide unit.
//
// Optional feature macro: RV32M_EN. When it is defined, R-type instructions with
// funct7[0] = 1 run on the MDU. When it is undefined they trap, the MDU states and
// counter are left out, and mdu_start_o is always 0.
//
// Parameters
//   MDU_LATENCY   MDU busy cycles per operation, 1..64
// Ports
//   clk_i, rst_i                  clock and synchronous active-high reset
//   op_i, funct3_i                IR[6:0], IR[14:12]
//   funct7_5_i, funct7_0_i        IR[30], IR[25]
//   mem_ready_i                   memory completes the current access this cycle
//   zero_i, lt_i, ltu_i           compare flags for A-B: equal, signed <, unsigned <
//   PCWrite_o, IRWrite_o          PC load enable; IR/OldPC load enable
//   AdrSrc_o                      memory address select (0 PC, 1 Result)
//   MemRead_o, MemWrite_o         memory requests
//   RegWrite_o                    register file write enable
//   ResultSrc_o                   00 ALUOut, 01 mem data, 10 ALUResult, 11 MDU
//   ALUSrcA_o                     00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB_o                     00 rs2, 01 imm, 10 constant 4
//   ImmSel_o                      I 000, S 001, B 010, J 011, U 100
//   ALUControl_o, ALUModifier_o   ALU operation (funct3 encoding) and SUB/SRA flag
//   mdu_start_o                   one-cycle MDU start pulse
//   retire_o                      one-cycle pulse when an instruction completes
//   illegal_o                     sticky illegal-instruction flag
module multicycle_control_unit #(
  parameter int MDU_LATENCY = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       funct7_0_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ImmSel_o,
  output logic [2:0] ALUControl_o,
  output logic       ALUModifier_o,
  output logic       mdu_start_o,
  output logic       retire_o,
  output logic       illegal_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // The MDU is split into an entry state (start pulse, counter load) and a busy
  // state that counts down and writes back once the counter holds zero.
  typedef enum logic [4:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_UTYPE,
    S_TRAP
`ifdef RV32M_EN
    , S_MDU_START,
    S_MDU_BUSY
`endif
  } state_t;

  state_t state;
  state_t next_state;

  // State register; reset always returns to FETCH, even mid-wait or mid-MDU.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

`ifdef RV32M_EN
  logic [5:0] mdu_cnt;

  // MDU busy counter: loaded on the entry cycle, counts down to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mdu_cnt <= 6'd0;
    end else if (state == S_MDU_START) begin
      mdu_cnt <= 6'(MDU_LATENCY - 1);
    end else if (state == S_MDU_BUSY && mdu_cnt != 6'd0) begin
      mdu_cnt <= mdu_cnt - 6'd1;
    end
  end
`else
  logic unused_mdu_latency;
  assign unused_mdu_latency = ^MDU_LATENCY;
`endif

  // Next-state and output decode. Every output gets a default first, then the
  // current state overrides only what it drives. Write enables and requests are
  // masked while reset is asserted.
  always_comb begin
    next_state    = state;
    PCWrite_o     = 1'b0;
    AdrSrc_o      = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    RegWrite_o    = 1'b0;
    ResultSrc_o   = 2'b00;
    ALUSrcA_o     = 2'b00;
    ALUSrcB_o     = 2'b00;
    ALUControl_o  = 3'b000;
    ALUModifier_o = 1'b0;
    mdu_start_o   = 1'b0;
    illegal_o     = 1'b0;

    case (op_i)
      OP_STORE:         ImmSel_o = 3'b001;
      OP_BRANCH:        ImmSel_o = 3'b010;
      OP_JAL:           ImmSel_o = 3'b011;
      OP_LUI, OP_AUIPC: ImmSel_o = 3'b100;
      default:          ImmSel_o = 3'b000;
    endcase

    case (state)
      S_FETCH: begin
        MemRead_o   = 1'b1;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        if (mem_ready_i) begin
          IRWrite_o  = 1'b1;
          PCWrite_o  = 1'b1;
          next_state = S_DECODE;
        end
      end

      // OldPC + imm is computed here so the branch/JAL target lands in ALUOut.
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        case (op_i)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R: begin
            if (funct7_0_i) begin
`ifdef RV32M_EN
              next_state = S_MDU_START;
`else
              next_state = S_TRAP;
`endif
            end else begin
              next_state = S_EXECR;
            end
          end
          OP_I:             next_state = S_EXECI;
          OP_BRANCH:        next_state = S_BRANCH;
          OP_JAL:           next_state = S_JAL;
          OP_JALR:          next_state = S_JALR;
          OP_LUI, OP_AUIPC: next_state = S_UTYPE;
          default:          next_state = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA_o  = 2'b10;
        ALUSrcB_o  = 2'b01;
        next_state = (op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        AdrSrc_o  = 1'b1;
        MemRead_o = 1'b1;
        if (mem_ready_i) begin
          next_state = S_MEMWB;
        end
      end

      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        RegWrite_o  = 1'b1;
        next_state  = S_FETCH;
      end

      S_MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        MemWrite_o = 1'b1;
        if (mem_ready_i) begin
          next_state = S_FETCH;
        end
      end

      S_EXECR: begin
        ALUSrcA_o     = 2'b10;
        ALUSrcB_o     = 2'b00;
        ALUControl_o  = funct3_i;
        ALUModifier_o = funct7_5_i;
        next_state    = S_ALUWB;
      end

      // For immediates funct7[5] is only an opcode bit for SRAI; elsewhere it is
      // part of the immediate and must not turn ADDI into a subtract.
      S_EXECI: begin
        ALUSrcA_o     = 2'b10;
        ALUSrcB_o     = 2'b01;
        ALUControl_o  = funct3_i;
        ALUModifier_o = (funct3_i == 3'b101) ? funct7_5_i : 1'b0;
        next_state    = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite_o = 1'b1;
        next_state = S_FETCH;
      end

      // rs1 - rs2 drives the flags; the target already sits in ALUOut.
      S_BRANCH: begin
        ALUSrcA_o     = 2'b10;
        ALUSrcB_o     = 2'b00;
        ALUModifier_o = 1'b1;
        next_state    = S_FETCH;
        case (funct3_i)
          3'b000:  PCWrite_o = zero_i;
          3'b001:  PCWrite_o = !zero_i;
          3'b100:  PCWrite_o = lt_i;
          3'b101:  PCWrite_o = !lt_i;
          3'b110:  PCWrite_o = ltu_i;
          3'b111:  PCWrite_o = !ltu_i;
          default: next_state = S_TRAP;
        endcase
      end

      S_JAL: begin
        PCWrite_o  = 1'b1;
        next_state = S_LINK;
      end

      S_JALR: begin
        ALUSrcA_o   = 2'b10;
        ALUSrcB_o   = 2'b01;
        ResultSrc_o = 2'b10;
        PCWrite_o   = 1'b1;
        next_state  = S_LINK;
      end

      // Link value is OldPC + 4.
      S_LINK: begin
        ALUSrcA_o   = 2'b01;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        RegWrite_o  = 1'b1;
        next_state  = S_FETCH;
      end

      // LUI adds the immediate to zero, AUIPC adds it to OldPC.
      S_UTYPE: begin
        ALUSrcA_o   = (op_i == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB_o   = 2'b01;
        ResultSrc_o = 2'b10;
        RegWrite_o  = 1'b1;
        next_state  = S_FETCH;
      end

`ifdef RV32M_EN
      S_MDU_START: begin
        mdu_start_o = 1'b1;
        next_state  = S_MDU_BUSY;
      end

      S_MDU_BUSY: begin
        if (mdu_cnt == 6'd0) begin
          ResultSrc_o = 2'b11;
          RegWrite_o  = 1'b1;
          next_state  = S_FETCH;
        end
      end
`endif

      S_TRAP: begin
        illegal_o = 1'b1;
      end

      default: next_state = S_FETCH;
    endcase

    retire_o = (state != S_FETCH) && (next_state == S_FETCH);

    if (rst_i) begin
      PCWrite_o   = 1'b0;
      IRWrite_o   = 1'b0;
      RegWrite_o  = 1'b0;
      MemRead_o   = 1'b0;
      MemWrite_o  = 1'b0;
      mdu_start_o = 1'b0;
      retire_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//
// Self-checking bench for multicycle_control_unit. Each instruction is driven
// from FETCH until it retires, every cycle's outputs are recorded, and the record
// is compared with what the instruction class must produce: cycle count, enable
// counts, writeback placement, execute-cycle mux settings and immediate type.
// Directed cases come first, followed by a randomized instruction stream.
module tb_multicycle_control_unit;

  localparam int LAT = 4;
  localparam int MAXC = 100;

  typedef enum int {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_MUL} cls_e;

  logic clk = 1'b0;
  logic rst, mem_ready, zero, lt, ltu;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7_5, funct7_0;
  logic pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_sel, alu_control;
  logic alu_modifier, mdu_start, retire, illegal;

  int checks = 0;
  int failures = 0;

  logic [1:0] a_s [MAXC];
  logic [1:0] b_s [MAXC];
  logic [1:0] res_s [MAXC];
  logic [2:0] alu_s [MAXC];
  logic [2:0] imm_s [MAXC];
  logic mod_s [MAXC];
  logic pcw_s [MAXC];
  logic rw_s [MAXC];
  logic ir_s [MAXC];
  logic mw_s [MAXC];
  logic mr_s [MAXC];
  logic ad_s [MAXC];
  logic ret_s [MAXC];
  logic st_s [MAXC];
  logic ill_s [MAXC];

  multicycle_control_unit #(.MDU_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct3_i(funct3),
    .funct7_5_i(funct7_5), .funct7_0_i(funct7_0), .mem_ready_i(mem_ready),
    .zero_i(zero), .lt_i(lt), .ltu_i(ltu),
    .PCWrite_o(pc_write), .AdrSrc_o(adr_src), .MemRead_o(mem_read),
    .MemWrite_o(mem_write), .IRWrite_o(ir_write), .RegWrite_o(reg_write),
    .ResultSrc_o(result_src), .ALUSrcA_o(alu_src_a), .ALUSrcB_o(alu_src_b),
    .ImmSel_o(imm_sel), .ALUControl_o(alu_control), .ALUModifier_o(alu_modifier),
    .mdu_start_o(mdu_start), .retire_o(retire), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] op_of(cls_e c);
    case (c)
      C_R, C_MUL: return 7'b0110011;
      C_I:        return 7'b0010011;
      C_LOAD:     return 7'b0000011;
      C_STORE:    return 7'b0100011;
      C_BR:       return 7'b1100011;
      C_JAL:      return 7'b1101111;
      C_JALR:     return 7'b1100111;
      C_LUI:      return 7'b0110111;
      default:    return 7'b0010111;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(cls_e c);
    case (c)
      C_STORE:        return 3'b001;
      C_BR:           return 3'b010;
      C_JAL:          return 3'b011;
      C_LUI, C_AUIPC: return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

  function automatic int base_cpi(cls_e c);
    case (c)
      C_LUI, C_AUIPC, C_BR: return 3;
      C_LOAD:               return 5;
      C_MUL:                return 3 + LAT;
      default:              return 4;
    endcase
  endfunction

  function automatic bit br_taken(logic [2:0] f3, logic z, logic l, logic lu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      default: return !lu;
    endcase
  endfunction

  // Drives one instruction cycle by cycle starting in FETCH. mem_ready is low for
  // the first fw cycles and for mw cycles from the memory access cycle onward.
  // n returns the retire cycle, or 0 if no retire came within max_cyc.
  task automatic apply_stimulus(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                                input logic f70, input int fw, input int mw, input bit is_mem,
                                input logic z, input logic l, input logic lu,
                                input int max_cyc, input bit stop_on_retire, output int n);
    op = o; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
    zero = z; lt = l; ltu = lu;
    n = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      mem_ready = (k > fw) && !(is_mem && k >= fw + 4 && k < fw + 4 + mw);
      @(negedge clk);
      a_s[k] = alu_src_a; b_s[k] = alu_src_b; res_s[k] = result_src;
      alu_s[k] = alu_control; imm_s[k] = imm_sel; mod_s[k] = alu_modifier;
      pcw_s[k] = pc_write; rw_s[k] = reg_write; ir_s[k] = ir_write;
      mw_s[k] = mem_write; mr_s[k] = mem_read; ad_s[k] = adr_src;
      ret_s[k] = retire; st_s[k] = mdu_start; ill_s[k] = illegal;
      @(posedge clk); #1;
      if (stop_on_retire && ret_s[k]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic run_instr(input string nm, input cls_e c, input logic [2:0] f3, input logic f75,
                           input int fw, input int mw, input logic z, input logic l, input logic lu);
    int n, e, exp_n, pcw_n, rw_n, ir_n, mw_n, st_n, imm_bad;
    bit is_mem, writes, taken;
    logic [1:0] ea, eb, eres;
    logic [2:0] ealu;
    logic emod;
    is_mem = (c == C_LOAD) || (c == C_STORE);
    apply_stimulus(op_of(c), f3, f75, (c == C_MUL), fw, mw, is_mem, z, l, lu, 60, 1'b1, n);
    exp_n = base_cpi(c) + fw + (is_mem ? mw : 0);
    check_output({nm, ".cycles"}, n, exp_n);
    if (n == 0) return;
    pcw_n = 0; rw_n = 0; ir_n = 0; mw_n = 0; st_n = 0; imm_bad = 0;
    for (int k = 1; k <= n; k++) begin
      pcw_n += int'(pcw_s[k]); rw_n += int'(rw_s[k]); ir_n += int'(ir_s[k]);
      mw_n += int'(mw_s[k]); st_n += int'(st_s[k]);
      if (imm_s[k] !== imm_of(c)) imm_bad++;
    end
    e = fw + 3;
    taken = (c == C_BR) && br_taken(f3, z, l, lu);
    writes = !(c == C_STORE || c == C_BR);
    check_output({nm, ".fetch_mux"}, {mr_s[fw + 1], ad_s[fw + 1], a_s[fw + 1], b_s[fw + 1], res_s[fw + 1]},
                 {1'b1, 1'b0, 2'b00, 2'b10, 2'b10});
    check_output({nm, ".irwrite_count"}, ir_n, 1);
    check_output({nm, ".pcwrite_count"}, pcw_n, 1 + int'(taken) + int'(c == C_JAL || c == C_JALR));
    check_output({nm, ".regwrite_count"}, rw_n, int'(writes));
    check_output({nm, ".memwrite_count"}, mw_n, (c == C_STORE) ? 1 + mw : 0);
    check_output({nm, ".mdu_start_count"}, st_n, int'(c == C_MUL));
    check_output({nm, ".imm_sel_bad_cycles"}, imm_bad, 0);
    check_output({nm, ".illegal"}, ill_s[n], 1'b0);
    if (writes) begin
      case (c)
        C_LOAD:  eres = 2'b01;
        C_MUL:   eres = 2'b11;
        C_R, C_I: eres = 2'b00;
        default: eres = 2'b10;
      endcase
      check_output({nm, ".wb_regwrite_resultsrc"}, {rw_s[n], res_s[n]}, {1'b1, eres});
    end
    if (c == C_MUL) check_output({nm, ".mdu_start_cycle"}, st_s[e], 1'b1);
    if (c == C_JAL || c == C_JALR) begin
      check_output({nm, ".link_mux"}, {a_s[n], b_s[n]}, {2'b01, 2'b10});
      check_output({nm, ".jump_pcwrite"}, pcw_s[e], 1'b1);
    end
    if (c != C_JAL && c != C_MUL) begin
      ea = 2'b10; eb = 2'b01; ealu = 3'b000; emod = 1'b0;
      case (c)
        C_R:     begin eb = 2'b00; ealu = f3; emod = f75; end
        C_I:     begin ealu = f3; emod = (f3 == 3'b101) ? f75 : 1'b0; end
        C_BR:    begin eb = 2'b00; emod = 1'b1; end
        C_LUI:   ea = 2'b11;
        C_AUIPC: ea = 2'b01;
        default: ;
      endcase
      check_output({nm, ".exec_mux_alu"}, {a_s[e], b_s[e], alu_s[e], mod_s[e]}, {ea, eb, ealu, emod});
    end
  endtask

  // Runs an instruction that must end in the trap state on cycle tc.
  task automatic run_trap(input string nm, input logic [6:0] o, input logic [2:0] f3,
                          input logic f70, input int tc);
    int n, wr_n, ill_n;
    apply_stimulus(o, f3, 1'b0, f70, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0, n);
    wr_n = 0; ill_n = 0;
    for (int k = 1; k <= 10; k++) begin
      wr_n += int'(rw_s[k]) + int'(mw_s[k]) + int'(ret_s[k]) + int'(ir_s[k] && k > 1) + int'(pcw_s[k] && k > 1);
      ill_n += int'(ill_s[k]);
    end
    check_output({nm, ".illegal_at_trap"}, {ill_s[tc - 1], ill_s[tc]}, 2'b01);
    check_output({nm, ".illegal_cycles"}, ill_n, 10 - tc + 1);
    check_output({nm, ".no_writes"}, wr_n, 0);
  endtask

  // Reset with the FSM wherever it is: enables must be masked during reset, and
  // afterwards the unit sits in FETCH with the illegal flag cleared.
  task automatic do_reset(input string nm);
    rst = 1'b1; mem_ready = 1'b1; op = 7'b0110011; funct7_0 = 1'b0;
    @(negedge clk);
    check_output({nm, ".masked_in_reset"},
                 {pc_write, ir_write, reg_write, mem_read, mem_write, mdu_start, retire}, 7'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output({nm, ".illegal_cleared"}, illegal, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check_output({nm, ".fetch_after_reset"}, {mem_read, ir_write, pc_write, alu_src_b, illegal},
                 {1'b1, 1'b0, 1'b0, 2'b10, 1'b0});
    @(posedge clk); #1;
  endtask

  initial begin
    cls_e pool [$];
    cls_e c;
    logic [2:0] f3;
    logic [2:0] br_f3 [6];
    rst = 1'b1; mem_ready = 1'b0; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; funct7_0 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    @(posedge clk); #1;
    do_reset("reset");

    run_instr("add", C_R, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("sub", C_R, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("load_waits", C_LOAD, 3'b010, 1'b0, 3, 2, 1'b0, 1'b0, 1'b0);
    run_instr("bne_not_taken", C_BR, 3'b001, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr("bne_taken", C_BR, 3'b001, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("jalr", C_JALR, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("jal", C_JAL, 3'b000, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    run_instr("lui", C_LUI, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("auipc", C_AUIPC, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("store_wait", C_STORE, 3'b010, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_instr("srai", C_I, 3'b101, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("addi_f75", C_I, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
`ifdef RV32M_EN
    run_instr("mul", C_MUL, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
`else
    run_trap("mul_no_m", 7'b0110011, 3'b000, 1'b1, 3);
    do_reset("reset_after_mul");
`endif
    run_trap("opcode0", 7'b0000000, 3'b000, 1'b0, 3);
    do_reset("reset_after_trap");
    run_trap("branch_f3_010", 7'b1100011, 3'b010, 1'b0, 4);
    do_reset("reset_after_branch_trap");

    pool = '{C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC};
`ifdef RV32M_EN
    pool.push_back(C_MUL);
`endif
    for (int i = 0; i < 40; i++) begin
      c = pool[$urandom_range(0, pool.size() - 1)];
      f3 = 3'($urandom_range(0, 7));
      if (c == C_BR) f3 = br_f3[$urandom_range(0, 5)];
      run_instr($sformatf("rand%0d", i), c, f3, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
